// File: rtl/fifo_8_to_32.sv
// Byte-to-word FIFO: packs a TCP RX byte stream little-endian into 32-bit words
// and presents them first-word-fall-through, with an RX byte count for SiTCP.
module fifo_8_to_32 #(
   parameter int DEPTH = 1024
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        WRITE,
   input  logic [7:0]  DATA_IN,
   input  logic        READ,
   output logic [31:0] DATA_OUT,
   output logic        EMPTY,
   output logic        FULL,
   output logic [15:0] RX_WC,
   output logic        OVERFLOW
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

   logic [31:0]   mem [DEPTH];
   logic [1:0]    bcnt_reg, bcnt_next;
   logic [23:0]   partial_reg, partial_next;
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
   logic [CW-1:0] count_reg, count_next;
   logic [31:0]   ram_q_reg, bypass_word_reg, word_next, bytes_next;
   logic [15:0]   rx_wc_reg, rx_wc_next;
   logic          bypass_reg, empty_reg, full_reg, overflow_reg;
   logic          pop, push, drop, accept;

   always_comb begin
      pop          = READ && !empty_reg;
      // A completing byte is only refused when no slot frees up this cycle.
      drop         = WRITE && (bcnt_reg == 2'd3) && (count_reg == DEPTH_C) && !pop;
      accept       = WRITE && !drop;
      push         = accept && (bcnt_reg == 2'd3);
      word_next    = {DATA_IN, partial_reg};
      bcnt_next    = accept ? bcnt_reg + 2'd1 : bcnt_reg;
      partial_next = partial_reg;
      if (accept) begin
         case (bcnt_reg)
            2'd0:    partial_next[7:0]   = DATA_IN;
            2'd1:    partial_next[15:8]  = DATA_IN;
            2'd2:    partial_next[23:16] = DATA_IN;
            default: partial_next        = partial_reg;
         endcase
      end
      rd_ptr_next = pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
      count_next  = count_reg + CW'(push) - CW'(pop);
      bytes_next  = 32'({count_next, bcnt_next});
      rx_wc_next  = (bytes_next > 32'h0000_FFFF) ? 16'hFFFF : bytes_next[15:0];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         bcnt_reg     <= '0;
         partial_reg  <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         empty_reg    <= 1'b1;
         full_reg     <= 1'b0;
         overflow_reg <= 1'b0;
         rx_wc_reg    <= '0;
         bypass_reg   <= 1'b0;
      end else begin
         bcnt_reg    <= bcnt_next;
         partial_reg <= partial_next;
         rd_ptr_reg  <= rd_ptr_next;
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         count_reg <= count_next;
         empty_reg <= (count_next == '0);
         full_reg  <= (count_next == DEPTH_C);
         if (drop) begin
            overflow_reg <= 1'b1;
         end
         rx_wc_reg  <= rx_wc_next;
         // The RAM returns old data when the head slot is written this edge.
         bypass_reg <= push && (wr_ptr_reg == rd_ptr_next);
      end
   end

   always_ff @(posedge CLK) begin
      if (push && !RST) begin
         mem[wr_ptr_reg] <= word_next;
      end
      ram_q_reg <= mem[rd_ptr_next];
   end

   always_ff @(posedge CLK) begin
      bypass_word_reg <= word_next;
   end

   assign DATA_OUT = empty_reg ? 32'h0 : (bypass_reg ? bypass_word_reg : ram_q_reg);
   assign EMPTY    = empty_reg;
   assign FULL     = full_reg;
   assign RX_WC    = rx_wc_reg;
   assign OVERFLOW = overflow_reg;

endmodule
